// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package cpu_pkg;

    typedef enum logic [2:0] {
        LEN0  = 3'd0,
        LEN1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_e;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // True for the states in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(input loader_state_e st);
        case (st)
            LEN0, LEN1, DATA: accepts_bytes = 1'b1;
            default:          accepts_bytes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles stream bytes into a 32-bit little-endian word, one lane per push.
// word shows the assembled word including the byte being pushed, and full
// flags the push that completes the word, so the caller can latch it directly.
module byte_packer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0]  lane_r;
    logic [31:0] word_r;
    logic [31:0] word_s;

    // Overlay the incoming byte onto its lane of the held partial word.
    always_comb begin
        word_s = word_r;
        case (lane_r)
            2'd0:    word_s[7:0]   = in_byte;
            2'd1:    word_s[15:8]  = in_byte;
            2'd2:    word_s[23:16] = in_byte;
            2'd3:    word_s[31:24] = in_byte;
            default: word_s        = word_r;
        endcase
    end

    // Lane counter and partial-word storage; the lane wraps after a full word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lane_r <= 2'd0;
            word_r <= 32'd0;
        end else if (clear) begin
            lane_r <= 2'd0;
            word_r <= 32'd0;
        end else if (push) begin
            lane_r <= lane_r + 2'd1;
            word_r <= word_s;
        end else begin
            lane_r <= lane_r;
            word_r <= word_r;
        end
    end

    assign word = word_s;
    assign full = push & (lane_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: takes a length-prefixed byte stream,
// packs it into words, writes consecutive addresses and holds the CPU in reset
// until the image is complete.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    loader_state_e     state_r, state_next_s;
    logic [7:0]        len_lo_r;
    logic [15:0]       count_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   words_loaded_r;
    logic              in_ready_r, imem_we_r, cpu_reset_r, done_r, error_r;
    logic [31:0]       imem_wdata_r;

    logic              fire_s, push_s, word_full_s, restart_s, last_word_s;
    logic [15:0]       header_s;
    logic [31:0]       word_s;

    assign fire_s      = in_valid & in_ready_r;
    assign push_s      = fire_s & (state_r == DATA);
    assign header_s    = {in_data, len_lo_r};
    assign restart_s   = start & ((state_r == DONE) | (state_r == ERR));
    assign last_word_s = (32'(words_loaded_r) + 32'd1) == {16'd0, count_r};

    byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (restart_s),
        .push    (push_s),
        .in_byte (in_data),
        .word    (word_s),
        .full    (word_full_s)
    );

    // Next-state decision for the header / data / write sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LEN0: begin
                if (fire_s) state_next_s = LEN1;
                else        state_next_s = LEN0;
            end
            LEN1: begin
                if (fire_s) begin
                    if ({16'd0, header_s} > CAPACITY) state_next_s = ERR;
                    else if (header_s == 16'd0)       state_next_s = DONE;
                    else                              state_next_s = DATA;
                end else begin
                    state_next_s = LEN1;
                end
            end
            DATA: begin
                if (word_full_s) state_next_s = WRITE;
                else             state_next_s = DATA;
            end
            WRITE: begin
                if (last_word_s) state_next_s = DONE;
                else             state_next_s = DATA;
            end
            DONE, ERR: begin
                if (start) state_next_s = LEN0;
                else       state_next_s = state_r;
            end
            default: state_next_s = LEN0;
        endcase
    end

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= LEN0;
            len_lo_r       <= 8'd0;
            count_r        <= 16'd0;
            addr_r         <= '0;
            words_loaded_r <= '0;
            in_ready_r     <= 1'b0;
            imem_we_r      <= 1'b0;
            imem_wdata_r   <= 32'd0;
            cpu_reset_r    <= 1'b1;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= accepts_bytes(state_next_s);
            imem_we_r   <= (state_next_s == WRITE);
            done_r      <= (state_next_s == DONE);
            error_r     <= (state_next_s == ERR);
            cpu_reset_r <= (state_next_s != DONE);

            if ((state_r == LEN0) && fire_s) len_lo_r <= in_data;
            else                             len_lo_r <= len_lo_r;

            if ((state_r == LEN1) && fire_s) count_r <= header_s;
            else                             count_r <= count_r;

            if (word_full_s) imem_wdata_r <= word_s;
            else             imem_wdata_r <= imem_wdata_r;

            // Address wraps naturally when a full-capacity image completes.
            if (restart_s) begin
                addr_r         <= '0;
                words_loaded_r <= '0;
            end else if (state_r == WRITE) begin
                addr_r         <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                words_loaded_r <= words_loaded_r + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                addr_r         <= addr_r;
                words_loaded_r <= words_loaded_r;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign imem_we      = imem_we_r;
    assign imem_addr    = addr_r;
    assign imem_wdata   = imem_wdata_r;
    assign cpu_reset    = cpu_reset_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// streams compared against a byte-stream reference model.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_valid = 1'b0;
    logic              start = 1'b0;
    logic              in_ready, imem_we, cpu_reset, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int unsigned wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write seen mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        clear_log();
    endtask

    // Offer each byte until accepted; optional random idle gaps.
    task automatic send(input bq_t q, input bit rnd);
        foreach (q[i]) begin
            int gap;
            int t;
            gap = rnd ? int'($urandom_range(0, 3)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                in_data = 8'($urandom_range(0, 255));
                tick();
            end
            in_valid = 1'b1;
            in_data = q[i];
            t = 0;
            while (in_ready !== 1'b1 && t < 50) begin
                tick();
                t++;
            end
            if (in_ready !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL send_timeout byte=%0d got in_ready=%b exp 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < budget) begin
            tick();
            t++;
        end
        total++;
        if (done !== 1'b1 && error !== 1'b1) begin
            bad++;
            $display("FAIL wait_done got done=%b error=%b exp completion", done, error);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h55;
        tick();
        tick();
        total++;
        if ({in_ready, imem_we, cpu_reset, done, error} !== 5'b00100) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00100", {in_ready, imem_we, cpu_reset, done, error});
        end
        total++;
        if (imem_addr !== '0 || imem_wdata !== 32'd0 || words_loaded !== '0) begin
            bad++;
            $display("FAIL reset_values got addr=%h wdata=%h wl=%0d exp 0", imem_addr, imem_wdata, words_loaded);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
        clear_log();
    endtask

    task automatic test_basic();
        bq_t s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        send(s, 1'b0);
        total++;
        if (imem_we !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_last_write got we=%b done=%b exp we=1 done=0", imem_we, done);
        end
        tick();
        total++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || words_loaded !== 9'd2) begin
            bad++;
            $display("FAIL basic_done got done=%b cpu_reset=%b wl=%0d exp 1 0 2", done, cpu_reset, words_loaded);
        end
        total++;
        if (wr_addr.size() != 2) begin
            bad++;
            $display("FAIL basic_count got=%0d exp=2", wr_addr.size());
        end else begin
            total++;
            if (wr_addr[0] != 0 || wr_data[0] !== 32'h12345678) begin
                bad++;
                $display("FAIL basic_w0 got %0d:%h exp 0:12345678", wr_addr[0], wr_data[0]);
            end
            total++;
            if (wr_addr[1] != 1 || wr_data[1] !== 32'hDEADBEEF) begin
                bad++;
                $display("FAIL basic_w1 got %0d:%h exp 1:deadbeef", wr_addr[1], wr_data[1]);
            end
            total++;
            if (wr_cyc[1] - wr_cyc[0] != 5) begin
                bad++;
                $display("FAIL basic_spacing got=%0d exp=5", wr_cyc[1] - wr_cyc[0]);
            end
        end
    endtask

    task automatic test_zero();
        bq_t s = '{8'h00, 8'h00};
        do_reset();
        send(s, 1'b0);
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b0) begin
            bad++;
            $display("FAIL zero_done got done=%b ready=%b cpu_reset=%b exp 1 0 0", done, in_ready, cpu_reset);
        end
        tick();
        total++;
        if (wr_addr.size() != 0) begin
            bad++;
            $display("FAIL zero_writes got=%0d exp=0", wr_addr.size());
        end
    endtask

    task automatic test_error();
        bq_t s = '{8'h01, 8'h01};
        do_reset();
        send(s, 1'b0);
        tick();
        total++;
        if (error !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL err_flags got err=%b ready=%b cpu_reset=%b done=%b exp 1 0 1 0", error, in_ready, cpu_reset, done);
        end
        total++;
        if (wr_addr.size() != 0) begin
            bad++;
            $display("FAIL err_writes got=%0d exp=0", wr_addr.size());
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (in_ready !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b1) begin
            bad++;
            $display("FAIL err_restart got ready=%b err=%b cpu_reset=%b exp 1 0 1", in_ready, error, cpu_reset);
        end
    endtask

    // Random streams with random valid gaps; expected words rebuilt from bytes.
    task automatic test_random();
        for (int iter = 0; iter < 5; iter++) begin
            bq_t s;
            int n;
            int errs;
            logic [31:0] expw;
            n = int'($urandom_range(1, 6));
            s.push_back(8'(n % 256));
            s.push_back(8'(n / 256));
            for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom_range(0, 255)));
            do_reset();
            send(s, 1'b1);
            wait_done(100);
            total++;
            if (wr_addr.size() != n || words_loaded !== 9'(n) || done !== 1'b1) begin
                bad++;
                $display("FAIL rand_count it=%0d got writes=%0d wl=%0d done=%b exp %0d", iter, wr_addr.size(), words_loaded, done, n);
            end else begin
                errs = 0;
                for (int w = 0; w < n; w++) begin
                    expw = 32'(s[2 + 4*w]) + (32'(s[3 + 4*w]) << 8)
                         + (32'(s[4 + 4*w]) << 16) + (32'(s[5 + 4*w]) << 24);
                    if (wr_addr[w] != w || wr_data[w] !== expw) begin
                        errs++;
                        $display("FAIL rand_word it=%0d w=%0d got %0d:%h exp %0d:%h", iter, w, wr_addr[w], wr_data[w], w, expw);
                    end
                end
                total++;
                if (errs != 0) bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bq_t s1 = '{8'h02, 8'h00, 8'h11, 8'h22};
        bq_t s2 = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        do_reset();
        send(s1, 1'b0);
        in_valid = 1'b1;
        in_data = 8'h33;
        reset = 1'b0;
        tick();
        total++;
        if ({in_ready, imem_we, cpu_reset, done, error} !== 5'b00100 ||
            imem_addr !== '0 || imem_wdata !== 32'd0 || words_loaded !== '0) begin
            bad++;
            $display("FAIL midreset_values got flags=%b addr=%h wdata=%h wl=%0d exp 00100 0 0 0",
                     {in_ready, imem_we, cpu_reset, done, error}, imem_addr, imem_wdata, words_loaded);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        clear_log();
        send(s2, 1'b0);
        total++;
        if (imem_we !== 1'b1 || imem_addr !== '0 || imem_wdata !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL midreset_fresh got we=%b addr=%h data=%h exp 1 0 cafef00d", imem_we, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_restart();
        bq_t s1 = '{8'h01, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11};
        bq_t s2 = '{8'h01, 8'h00, 8'h22, 8'h22, 8'h22, 8'h22};
        do_reset();
        send(s1, 1'b0);
        wait_done(20);
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || words_loaded !== '0 || imem_addr !== '0) begin
            bad++;
            $display("FAIL restart_clear got cpu_reset=%b done=%b wl=%0d addr=%h exp 1 0 0 0", cpu_reset, done, words_loaded, imem_addr);
        end
        send(s2, 1'b0);
        wait_done(20);
        total++;
        if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] !== 32'h22222222 || done !== 1'b1) begin
            bad++;
            $display("FAIL restart_write got writes=%0d done=%b exp one write 0:22222222", wr_addr.size(), done);
        end
    endtask

    // Full-capacity image: last write at the top address, address wraps to 0.
    task automatic test_full();
        bq_t s;
        int n = 1 << ADDR_W;
        int errs = 0;
        logic [31:0] expw;
        s.push_back(8'(n % 256));
        s.push_back(8'(n / 256));
        for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom_range(0, 255)));
        do_reset();
        send(s, 1'b0);
        wait_done(20);
        total++;
        if (wr_addr.size() != n || words_loaded !== 9'(n) || imem_addr !== '0 || done !== 1'b1) begin
            bad++;
            $display("FAIL full_end got writes=%0d wl=%0d addr=%h done=%b exp %0d %0d 0 1", wr_addr.size(), words_loaded, imem_addr, done, n, n);
        end else begin
            for (int w = 0; w < n; w++) begin
                expw = 32'(s[2 + 4*w]) | (32'(s[3 + 4*w]) << 8)
                     | (32'(s[4 + 4*w]) << 16) | (32'(s[5 + 4*w]) << 24);
                if (wr_addr[w] != w || wr_data[w] !== expw) errs++;
            end
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL full_words got errors=%0d exp 0", errs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_error();
        test_random();
        test_reset_mid();
        test_restart();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
